// File: rtl/syn_fifo_thresh_if.sv
// Bundles the FIFO's producer/consumer signals. The master side drives the FIFO
// and the slave side is the FIFO itself.
interface syn_fifo_thresh_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output w_en, data_in, r_en, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/syn_fifo_thresh.sv
// Single-clock FIFO with exact occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Define SYN_FIFO_THRESH_FWFT_EN for first-word-fall-through reads; the default
// build uses a registered read with one cycle of latency.
module syn_fifo_thresh #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    syn_fifo_thresh_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         w_ptr;
    logic [AW-1:0]         r_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_c;
    logic                  empty_c;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status decodes of the registered occupancy.
    assign full_c           = (count_q == CW'(DEPTH));
    assign empty_c          = (count_q == '0);
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // A request is only accepted when the FIFO can honour it this cycle.
    assign wr_ok = bus.w_en & ~full_c;
    assign rd_ok = bus.r_en & ~empty_c;

    // Storage array; deliberately not reset, pointers make stale data unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[w_ptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + AW'(1);
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + AW'(1);
            end
            count_q <= count_q + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.w_en && full_c) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.r_en && empty_c) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

`ifdef SYN_FIFO_THRESH_FWFT_EN
    // Head entry is presented directly; zero when nothing is stored.
    assign bus.data_out = empty_c ? '0 : mem[r_ptr];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    // Registered read port; holds the last popped word between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= mem[r_ptr];
        end
    end

    assign bus.data_out = dout_q;
`endif

endmodule
